// File: rtl/l2_alloc_ctrl.sv
// l2_alloc_ctrl: allocation/replacement controller in front of the L2 tag array
module l2_alloc_ctrl #(
    parameter int TL_AW = 28
) (
    input  logic             l2_clock_i,
    input  logic             l2_resetn_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [TL_AW-8:0] req_line_i,
    input  logic             req_inv_i,
    output logic [TL_AW-8:0] lookup_line_o,
    input  logic [3:0]       tag_set_bitvec_i,
    input  logic [3:0]       tag_total_match_i,
    input  logic             tag_valid_i,
    input  logic [1:0]       tag_set_enc_i,
    output logic [TL_AW-8:0] ins_line_o,
    output logic [1:0]       ins_way_o,
    output logic             ins_o,
    output logic             ins_present_o,
    output logic             fill_valid_o,
    input  logic             fill_ready_i,
    output logic [TL_AW-8:0] fill_line_o,
    output logic [1:0]       fill_way_o,
    output logic             fill_victim_valid_o,
    input  logic             fill_done_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic             resp_hit_o,
    output logic [1:0]       resp_way_o
);
    localparam int LW = TL_AW - 7;

    typedef enum logic [2:0] {
        INIT, IDLE, LOOKUP, FILL_REQ, FILL_WAIT, INSERT, RESP
    } state_e;

    state_e        state_q, state_d;
    logic [9:0]    cnt_q, cnt_d;
    logic [LW-1:0] line_q, line_d;
    logic          inv_q, inv_d;
    logic          hit_q, hit_d;
    logic          vv_q, vv_d;
    logic [1:0]    way_q, way_d;
    logic [2:0]    plru_q [256];
    logic [2:0]    plru_cur, plru_new;
    logic [1:0]    plru_way, plru_vic, vic_way;
    logic          plru_we;
    logic          hit;
    logic          run;

    assign run      = l2_resetn_i;
    assign hit      = tag_valid_i && |tag_total_match_i;
    assign plru_cur = plru_q[line_q[7:0]];
    assign plru_vic = plru_cur[0] ? {1'b1, plru_cur[2]} : {1'b0, plru_cur[1]};
    assign plru_new = plru_way[1] ? {~plru_way[0], plru_cur[1], 1'b0}
                                  : {plru_cur[2], ~plru_way[0], 1'b1};
    assign vic_way  = !tag_set_bitvec_i[0] ? 2'd0 :
                      !tag_set_bitvec_i[1] ? 2'd1 :
                      !tag_set_bitvec_i[2] ? 2'd2 :
                      !tag_set_bitvec_i[3] ? 2'd3 : plru_vic;

    // Next-state logic: sweep, lookup decision, fill handshake, insert and response
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        line_d   = line_q;
        inv_d    = inv_q;
        hit_d    = hit_q;
        way_d    = way_q;
        vv_d     = vv_q;
        plru_we  = 1'b0;
        plru_way = way_q;
        case (state_q)
            INIT: begin
                cnt_d   = cnt_q + 10'd1;
                state_d = (cnt_q == 10'd1023) ? IDLE : INIT;
            end
            IDLE: if (req_valid_i) begin
                line_d  = req_line_i;
                inv_d   = req_inv_i;
                state_d = LOOKUP;
            end
            LOOKUP: if (hit) begin
                hit_d    = 1'b1;
                way_d    = tag_set_enc_i;
                plru_we  = ~inv_q;
                plru_way = tag_set_enc_i;
                state_d  = inv_q ? INSERT : RESP;
            end else if (inv_q) begin
                hit_d   = 1'b0;
                way_d   = 2'd0;
                state_d = RESP;
            end else begin
                hit_d   = 1'b0;
                way_d   = vic_way;
                vv_d    = &tag_set_bitvec_i;
                state_d = FILL_REQ;
            end
            FILL_REQ:  if (fill_ready_i) state_d = FILL_WAIT;
            FILL_WAIT: if (fill_done_i) state_d = INSERT;
            INSERT: begin
                plru_we = ~inv_q;
                state_d = RESP;
            end
            RESP:      if (resp_ready_i) state_d = IDLE;
            default:   state_d = INIT;
        endcase
    end

    // Control state registers; reset restarts the sweep and abandons any fill
    always_ff @(posedge l2_clock_i) begin
        if (!l2_resetn_i) begin
            state_q <= INIT;
            cnt_q   <= '0;
            line_q  <= '0;
            inv_q   <= 1'b0;
            hit_q   <= 1'b0;
            way_q   <= '0;
            vv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            inv_q   <= inv_d;
            hit_q   <= hit_d;
            way_q   <= way_d;
            vv_q    <= vv_d;
        end
    end

    // PLRU storage: cleared set-by-set during the sweep, updated on hit or insert
    always_ff @(posedge l2_clock_i) begin
        if (l2_resetn_i && state_q == INIT) plru_q[cnt_q[9:2]] <= '0;
        else if (l2_resetn_i && plru_we) plru_q[line_q[7:0]] <= plru_new;
    end

    // Outputs decoded from state; everything is forced quiet while reset is held
    always_comb begin
        lookup_line_o       = line_q;
        req_ready_o         = run && state_q == IDLE;
        ins_o               = run && (state_q == INIT || state_q == INSERT);
        ins_present_o       = run && state_q == INSERT && !inv_q;
        ins_line_o          = !run ? '0 :
                              state_q == INIT ? {{(LW-8){1'b0}}, cnt_q[9:2]} :
                              state_q == INSERT ? line_q : '0;
        ins_way_o           = !run ? '0 :
                              state_q == INIT ? cnt_q[1:0] :
                              state_q == INSERT ? way_q : '0;
        fill_valid_o        = run && state_q == FILL_REQ;
        fill_line_o         = fill_valid_o ? line_q : '0;
        fill_way_o          = fill_valid_o ? way_q : '0;
        fill_victim_valid_o = fill_valid_o && vv_q;
        resp_valid_o        = run && state_q == RESP;
        resp_hit_o          = resp_valid_o && hit_q;
        resp_way_o          = resp_valid_o ? way_q : '0;
    end
endmodule

// File: doc/l2_alloc_ctrl.md
Name: l2_alloc_ctrl

Overview:
- Allocation/replacement controller sitting directly in front of the L2 tag array.
- Accepts lookup/invalidate requests, drives the tag array's lookup line and consumes its hit results (set_bitvec, total_match, valid, set_enc).
- On a miss it picks a victim way (first invalid way, else tree-PLRU), hands the refill to the fill engine, then writes the new tag via the tag insert port.
- After reset it sweeps all 256 sets to invalidate tags and clear PLRU state.

Parameters:
- TL_AW, 28, TileLink address width; cache line number is TL_AW-7 bits, index = line[7:0], tag = line[TL_AW-8:8].

Ports:
- l2_clock_i  in  1  clock.
- l2_resetn_i  in  1  reset, synchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&ready.
- req_line_i  in  TL_AW-7  cache line number.
- req_inv_i  in  1  1=invalidate request, 0=allocate lookup.
- lookup_line_o  out  TL_AW-7  to tag array cache_line.
- tag_set_bitvec_i  in  4  from tag array set_bitvec.
- tag_total_match_i  in  4  from tag array total_match.
- tag_valid_i  in  1  from tag array valid.
- tag_set_enc_i  in  2  from tag array set_enc.
- ins_line_o  out  TL_AW-7  to cache_line_insert.
- ins_way_o  out  2  to set_to_insert_in.
- ins_o  out  1  to insert.
- ins_present_o  out  1  to insert_present.
- fill_valid_o  out  1  refill request valid.
- fill_ready_i  in  1  fill engine accepts.
- fill_line_o  out  TL_AW-7  line to fetch.
- fill_way_o  out  2  destination way.
- fill_victim_valid_o  out  1  victim way holds valid data (engine writes back by index+way).
- fill_done_i  in  1  single-cycle pulse, refill complete.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  response consumed.
- resp_hit_o  out  1  request hit.
- resp_way_o  out  2  hit way or allocated way.

Behaviour:
- Reset (l2_resetn_i=0 at posedge) from any state, including mid-fill:
  - enter INIT with sweep counter 0.
  - outputs: req_ready_o=0, ins_o=0, fill_valid_o=0, resp_valid_o=0; all data outputs 0.
  - A fill in flight is abandoned; fill_done_i is ignored outside FILL_WAIT.
- INIT:
  - 10-bit counter c. Each cycle: ins_o=1, ins_present_o=0, ins_line_o[7:0]=c[9:2], upper bits 0, ins_way_o=c[1:0].
  - PLRU[c[9:2]] cleared to 3'b000.
  - After c=1023 go to IDLE. Sweep takes 1024 cycles.
- IDLE: req_ready_o=1. On handshake, register line and inv, go to LOOKUP. lookup_line_o always drives the registered line.
- LOOKUP (1 cycle, tag results combinational):
  - hit, not inv: PLRU update with tag_set_enc_i; resp hit=1, way=set_enc; go RESP.
  - hit, inv: go INSERT with ins_present_o=0, way=set_enc, no PLRU update; resp hit=1.
  - miss, inv: resp hit=0, way=0; go RESP.
  - miss, not inv:
    - if ~&tag_set_bitvec_i, victim = lowest-index 0 bit and fill_victim_valid=0.
    - else victim = PLRU way and fill_victim_valid=1.
    - go FILL_REQ.
- FILL_REQ: fill_valid_o=1 with line/way/victim_valid held stable until fill_ready_i; then FILL_WAIT.
- FILL_WAIT: wait for fill_done_i, then INSERT. A fill_done_i arriving in the same cycle as the FILL_REQ handshake is ignored.
- INSERT (1 cycle): ins_o=1, ins_line_o=req line, ins_way_o=victim, ins_present_o=1; PLRU update with victim; resp hit=0, way=victim; go RESP. For the inv path: ins_present_o=0, no PLRU update.
- RESP: resp_valid_o=1, outputs held until resp_ready_i; then IDLE. Next request is accepted one cycle after the response handshake.
- Tag-port exclusivity: ins_o is asserted only in INIT and INSERT; lookup results are used only in LOOKUP. A tag written in INSERT is visible to the next request's LOOKUP.
- PLRU:
  - Storage: 256 x 3 bits {b2,b1,b0}, read by req index.
  - Victim: b0=0 selects {0,1} using b1 (0 selects way0, 1 selects way1); b0=1 selects {2,3} using b2 (0 selects way2, 1 selects way3).
  - Access to way w: b0 <= ~w[1]; if w[1]==0 then b1 <= ~w[0], else b2 <= ~w[0].

Test Plan:
- Reset sweep: hold reset 2 cycles, release -> exactly 1024 cycles of ins_o=1, ins_present_o=0, (index, way) stepping (0,0),(0,1)...(255,3), req_ready_o=0 throughout, then req_ready_o=1.
- Cold miss: line 0x123, inv=0 -> fill_way_o=0, fill_victim_valid_o=0; after fill_done_i, ins_o for one cycle with way 0, present=1; response hit=0, way=0. Re-request 0x123 -> response hit=1, way=0, no fill.
- Set fill and PLRU: lines 0x001, 0x101, 0x201, 0x301 -> allocated ways 0,1,2,3. Line 0x401 -> way0 with victim_valid=1. Then hit 0x101 (way1), miss 0x501 -> victim way2.
- Invalidate: inv request to a resident line in way1 -> ins_o with way1, present=0, response hit=1. Repeat lookup -> hit=0.
- Back-pressure: fill_ready_i low 5 cycles, then resp_ready_i low 3 cycles -> fill and response outputs stable, req_ready_o=0, no extra ins_o.
- Reset mid-fill in FILL_WAIT -> fill_valid_o=0 next cycle, INIT sweep restarts from 0. A later fill_done_i pulse has no effect.
